// File: rtl/slow_clock_monitor_if.sv
// Result bundle of slow_clock_monitor: edge pulse, period and gate-window edge count.
// With MINMAX_EN defined it also carries the running min/max period.
interface slow_clock_monitor_if #(
  parameter int CNT_W  = 28,
  parameter int FREQ_W = 16
);
  logic              edge_tick;
  logic [CNT_W-1:0]  period;
  logic              period_valid;
  logic [FREQ_W-1:0] freq_count;
  logic              freq_valid;
  logic              stuck;
`ifdef MINMAX_EN
  logic [CNT_W-1:0]  period_min;
  logic [CNT_W-1:0]  period_max;
`endif

  modport master (
    output edge_tick, period, period_valid, freq_count, freq_valid, stuck
`ifdef MINMAX_EN
    , period_min, period_max
`endif
  );

  modport slave (
    input edge_tick, period, period_valid, freq_count, freq_valid, stuck
`ifdef MINMAX_EN
    , period_min, period_max
`endif
  );
endinterface

// File: rtl/slow_clock_monitor.sv
// Synchronises a slow divider output, measures its period, counts edges per gate
// window and flags a stuck clock. Optional MINMAX_EN adds min/max period tracking.
module slow_clock_monitor #(
  parameter int SYS_CLK = 100000000,
  parameter int GATE    = SYS_CLK,
  parameter int TIMEOUT = 2 * SYS_CLK,
  parameter int CNT_W   = 28,
  parameter int FREQ_W  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clk_in_i,
`ifdef MINMAX_EN
  input  logic minmax_clr_i,
`endif
  slow_clock_monitor_if.master mon_o
);
  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  cnt_q, gate_q, period_q;
  logic [FREQ_W-1:0] edge_acc_q, freq_q;
  logic              edge_tick_q, period_valid_q, freq_valid_q, stuck_q;

  logic              rise;
  logic              gate_wrap;
  logic [CNT_W-1:0]  period_d;
  logic [FREQ_W-1:0] acc_d;

  assign rise      = s2_q & ~s3_q & en_i;
  assign gate_wrap = en_i && (gate_q == GATE_LAST);
  assign period_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign acc_d     = (rise && edge_acc_q != '1) ? edge_acc_q + 1'b1 : edge_acc_q;

  // The synchroniser keeps sampling while disabled so re-enable sees a settled level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      gate_q         <= '0;
      period_q       <= '0;
      edge_acc_q     <= '0;
      freq_q         <= '0;
      edge_tick_q    <= 1'b0;
      period_valid_q <= 1'b0;
      freq_valid_q   <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      edge_tick_q    <= rise;
      period_valid_q <= 1'b0;
      freq_valid_q   <= 1'b0;
      if (en_i) begin
        gate_q <= gate_wrap ? '0 : gate_q + 1'b1;
        if (gate_wrap) begin
          freq_q       <= acc_d;
          freq_valid_q <= 1'b1;
          edge_acc_q   <= '0;
        end else begin
          edge_acc_q <= acc_d;
        end

        // cnt_q doubles as the no-edge timeout counter in IDLE and MEASURE.
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= '0;
            end else if (cnt_q == TO_LAST) begin
              state_q <= STUCK;
              stuck_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q       <= period_d;
              period_valid_q <= 1'b1;
              cnt_q          <= '0;
            end else if (cnt_q == TO_LAST) begin
              state_q <= STUCK;
              stuck_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          STUCK: begin
            cnt_q <= '0;
            if (rise) begin
              state_q <= MEASURE;
              stuck_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

`ifdef MINMAX_EN
  logic [CNT_W-1:0] period_min_q, period_max_q;

  always_ff @(posedge clk) begin
    if (rst || minmax_clr_i) begin
      period_min_q <= '1;
      period_max_q <= '0;
    end else if (rise && state_q == MEASURE) begin
      if (period_d < period_min_q) period_min_q <= period_d;
      if (period_d > period_max_q) period_max_q <= period_d;
    end
  end

  assign mon_o.period_min = period_min_q;
  assign mon_o.period_max = period_max_q;
`endif

  assign mon_o.edge_tick    = edge_tick_q;
  assign mon_o.period       = period_q;
  assign mon_o.period_valid = period_valid_q;
  assign mon_o.freq_count   = freq_q;
  assign mon_o.freq_valid   = freq_valid_q;
  assign mon_o.stuck        = stuck_q;
endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor (GATE=100, TIMEOUT=50); MINMAX_EN adds min/max steps.
module tb_slow_clock_monitor;
  localparam int CNT_W   = 28;
  localparam int FREQ_W  = 16;
  localparam int GATE    = 100;
  localparam int TIMEOUT = 50;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic en     = 1'b0;
  logic clk_in = 1'b0;
`ifdef MINMAX_EN
  logic minmax_clr = 1'b0;
  int   last_hi;
`endif

  slow_clock_monitor_if #(.CNT_W(CNT_W), .FREQ_W(FREQ_W)) mon ();

  slow_clock_monitor #(
    .GATE(GATE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .FREQ_W(FREQ_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_i(en),
    .clk_in_i(clk_in),
`ifdef MINMAX_EN
    .minmax_clr_i(minmax_clr),
`endif
    .mon_o(mon)
  );

  always #5 clk = ~clk;

  int cyc, ph;
  bit wave_on;
  int ticks, pv, fv, first_tick, first_stuck, last_period, last_freq;
  int ticks_s, pv_s, fv_s;
  int checks, errors;

  // One clock; clk_in toggles every 5 cycles while wave_on; pulses are tallied.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (wave_on) begin
      ph++;
      if (ph == 5) begin
        clk_in = ~clk_in;
        ph = 0;
      end
    end
    if (mon.edge_tick) begin
      ticks++;
      if (first_tick < 0) first_tick = cyc;
    end
    if (mon.period_valid) begin
      pv++;
      last_period = int'(mon.period);
    end
    if (mon.freq_valid) begin
      fv++;
      last_freq = int'(mon.freq_count);
    end
    if (mon.stuck && first_stuck < 0) first_stuck = cyc;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
    $display("check %-16s got %0d expected %0d", tag, obs, exp);
  endtask

`ifdef MINMAX_EN
  // Raise clk_in for one cycle exactly gap cycles after the previous raise.
  task automatic hi_at(input int gap);
    int target;
    target = last_hi + gap;
    clk_in = 1'b0;
    while (cyc < target) step();
    clk_in = 1'b1;
    last_hi = cyc;
    step();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; ph = 0; wave_on = 1'b0;
    ticks = 0; pv = 0; fv = 0; first_tick = -1; first_stuck = -1;
    last_period = 0; last_freq = 0;

    // Reset with clk_in low
    repeat (3) step();
    check("rst_edge_tick", 32'(mon.edge_tick), 32'd0);
    check("rst_period", 32'(mon.period), 32'd0);
    check("rst_period_vld", 32'(mon.period_valid), 32'd0);
    check("rst_freq", 32'(mon.freq_count), 32'd0);
    check("rst_freq_vld", 32'(mon.freq_valid), 32'd0);
    check("rst_stuck", 32'(mon.stuck), 32'd0);

    // Period-10 wave, two full gate windows
    rst = 1'b0; en = 1'b1; cyc = 0; ph = 0; wave_on = 1'b1;
    ticks = 0; pv = 0; fv = 0;
    repeat (100) step();
    check("first_tick_cyc", 32'(first_tick), 32'd8);
    check("win1_fv", 32'(fv), 32'd1);
    check("win1_freq", 32'(last_freq), 32'd10);
    repeat (100) step();
    check("win2_fv", 32'(fv), 32'd2);
    check("win2_freq", 32'(last_freq), 32'd10);
    check("ticks_200", 32'(ticks), 32'd20);
    check("pv_200", 32'(pv), 32'd19);
    check("period_10", 32'(mon.period), 32'd10);

    // Stall low: stuck 50 cycles after the last edge_tick (cycle 198)
    wave_on = 1'b0;
    while (cyc < 260) step();
    check("stuck_cycle", 32'(first_stuck), 32'd248);
    check("stuck_level", 32'(mon.stuck), 32'd1);
    check("stuck_no_pv", 32'(pv), 32'd19);

    // Recover: first rise clears stuck without a period, second gives 10
    ph = 0; wave_on = 1'b1; ticks_s = ticks;
    while (cyc < 270) step();
    check("recover_stuck", 32'(mon.stuck), 32'd0);
    check("recover_ticks", 32'(ticks - ticks_s), 32'd1);
    check("recover_no_pv", 32'(pv), 32'd19);
    while (cyc < 280) step();
    check("recover_pv", 32'(pv), 32'd20);
    check("recover_period", 32'(last_period), 32'd10);

    // EN low for 25 cycles
    while (cyc < 281) step();
    en = 1'b0; ticks_s = ticks; pv_s = pv; fv_s = fv;
    while (cyc < 306) step();
    check("dis_ticks", 32'(ticks), 32'(ticks_s));
    check("dis_pv", 32'(pv), 32'(pv_s));
    check("dis_fv", 32'(fv), 32'(fv_s));
    en = 1'b1;
    step();
    check("reen_no_pv", 32'(pv), 32'(pv_s));
    step();
    check("reen_tick", 32'(mon.edge_tick), 32'd1);
    check("reen_pv", 32'(mon.period_valid), 32'd1);
    check("reen_period", 32'(mon.period), 32'd5);
    while (cyc < 324) step();
    check("gate_frozen", 32'(fv), 32'(fv_s));
    step();
    check("win3_fv", 32'(mon.freq_valid), 32'd1);
    check("win3_freq", 32'(mon.freq_count), 32'd4);

    // One-cycle reset pulse mid-window
    while (cyc < 330) step();
    rst = 1'b1;
    step();
    check("mid_rst_period", 32'(mon.period), 32'd0);
    check("mid_rst_freq", 32'(mon.freq_count), 32'd0);
    check("mid_rst_stuck", 32'(mon.stuck), 32'd0);
    check("mid_rst_pv", 32'(mon.period_valid), 32'd0);
    check("mid_rst_fv", 32'(mon.freq_valid), 32'd0);
    check("mid_rst_tick", 32'(mon.edge_tick), 32'd0);
    rst = 1'b0; pv_s = pv;
    while (cyc < 338) step();
    check("post_rst_tick", 32'(mon.edge_tick), 32'd1);
    check("post_rst_no_pv", 32'(pv), 32'(pv_s));
    while (cyc < 348) step();
    check("post_rst_pv", 32'(mon.period_valid), 32'd1);
    check("post_rst_period", 32'(mon.period), 32'd10);

`ifdef MINMAX_EN
    // Periods 10, 14, 8 after a clear
    wave_on = 1'b0; last_hi = 345;
    hi_at(10);
    while (cyc < 358) step();
    minmax_clr = 1'b1;
    step();
    minmax_clr = 1'b0;
    check("clr_min", 32'(mon.period_min), 32'h0FFF_FFFF);
    check("clr_max", 32'(mon.period_max), 32'd0);
    hi_at(10);
    hi_at(14);
    hi_at(8);
    while (cyc < 391) step();
    check("mm_period", 32'(mon.period), 32'd8);
    check("mm_min", 32'(mon.period_min), 32'd8);
    check("mm_max", 32'(mon.period_max), 32'd14);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
